rpn_eval: RTL and testbench
===========================

// Module: rpn_eval
// PURPOSE
//  Consumes the postfix (RPN) ASCII stream emitted by the infix-to-RPN converter and evaluates it on an integer stack.
//  For each expression it emits the result as ASCII decimal, or 'E' on error, followed by 0x0A.
//  Both sides use the STB/ACK character handshake: upstream is the converter, downstream is a UART/display sink.
// PARAMETERS
//  WIDTH  32  signed operand/stack word width, 8..32 (10-digit output buffer sized for 32)
//  DEPTH  8   stack entries, >=2
// PORTS
//  CLK       in   1  clock, all state on rising edge
//  RST       in   1  asynchronous, active-low reset
//  IN_STB    in   1  IN_CHAR valid
//  IN_CHAR   in   8  RPN character
//  IN_ACK    out  1  ready; char consumed on cycle with IN_STB && IN_ACK
//  OUT_STB   out  1  OUT_CHAR valid, held until taken
//  OUT_CHAR  out  8  result character
//  OUT_ACK   in   1  sink took OUT_CHAR on cycle with OUT_STB && OUT_ACK
// BEHAVIOUR
//  Reset (async assert, sync release): IN_ACK=1, OUT_STB=0, OUT_CHAR=8'h00, stack empty, acc cleared, err=0, state IDLE.
//  Input alphabet:
//   - '0'-'9': acc=acc*10+d (mod 2^WIDTH), sets num_pend.
//   - ' ' (0x20): if num_pend, push acc.
//   - '+' '-' '*' '/': flush pending number first, then pop b, pop a, push a op b.
//   - '=': flush pending number, then finish expression.
//   - Any other char (incl. '(' ')'): err=1.
//  Arithmetic: two's complement. + - * wrap mod 2^WIDTH; '/' truncates toward zero; b==0 -> err.
//  Errors: push with DEPTH entries -> err (overflow); operator with <2 entries -> err (underflow).
//   Once err=1, chars are consumed and discarded until '='.
//  States:
//   - IDLE: IN_ACK=1. On accept -> EXEC; IN_ACK=0 the following cycle.
//   - EXEC: one cycle; apply the char. Non-'=' -> IDLE.
//     '=' with err=1 or stack count!=1 -> SEND of "E",0x0A; otherwise -> CONV.
//   - CONV: mag=|top| as unsigned WIDTH bits, so -2^(WIDTH-1) converts correctly.
//     One digit per cycle (mag%10 into buffer, mag/=10) until mag==0; minimum one digit; records sign.
//   - SEND: emits '-' if negative, digits MSB first, then 0x0A.
//     OUT_STB=1 with OUT_CHAR stable until OUT_ACK; next char is presented the cycle after the ack.
//     After the 0x0A ack: clear stack/acc/err -> IDLE.
//  Throughput: one input char per 2 cycles. IN_ACK=0 throughout CONV/SEND; IN_STB there is ignored, and upstream holds it.
//  OUT_STB=0 outside SEND. OUT_ACK while OUT_STB=0 is ignored.
//  Reset mid-expression or mid-SEND drops everything immediately; no partial output resumes.
//  Number then operator with no space ("3+") is legal: the operator flushes the number.
// CONFIGURATION
//  RPN_MOD_EN defined:   '%' (0x25) is an operator: a%b, sign follows a (truncating), b==0 -> err.
//  RPN_MOD_EN undefined: '%' is an illegal char -> err.
// TESTING
//  "12 3+=" -> '1','5',0x0A; IN_ACK high again after the 0x0A ack.
//  "2 7-=" -> '-','5',0x0A. "2147483647 1+=" -> "-2147483648",0x0A (WIDTH=32).
//  "8 0/=" -> 'E',0x0A; then "4 4*=" -> '1','6',0x0A (error recovery).
//  "+=" -> 'E',0x0A. DEPTH=4: "1 2 3 4 5 ++++=" -> 'E',0x0A (overflow). "1 2=" -> 'E',0x0A.
//  OUT_ACK held 0 for 5 cycles on the first digit -> OUT_CHAR stable, OUT_STB=1, IN_ACK=0.
//   RST low mid-SEND -> OUT_STB=0 immediately; after release "5=" -> '5',0x0A.
//  "17 5%=" -> '2',0x0A with RPN_MOD_EN; 'E',0x0A without.

Source files
------------

// File: rtl/rpn_eval.sv
// rpn_eval: evaluates a postfix ASCII stream on a signed integer stack and emits the result as ASCII decimal (or 'E') followed by 0x0A.
// Optional feature macro RPN_MOD_EN: when defined, '%' is a remainder operator; otherwise it is an illegal character.
module rpn_eval #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IN_STB,
    input  logic [7:0] IN_CHAR,
    output logic       IN_ACK,
    output logic       OUT_STB,
    output logic [7:0] OUT_CHAR,
    input  logic       OUT_ACK
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CONV, S_SEND} state_t;

    state_t                   r_state, w_next;
    logic [7:0]               r_char;
    logic signed [WIDTH-1:0]  r_stack [DEPTH];
    logic [CW-1:0]            r_cnt;
    logic [WIDTH-1:0]         r_acc;
    logic                     r_pend;
    logic                     r_err;
    logic [WIDTH-1:0]         r_mag;
    logic                     r_neg;
    logic [3:0]               r_dig [10];
    logic [3:0]               r_ndig;
    logic [3:0]               r_ptr;
    logic                     r_last;
    logic                     r_out_stb;
    logic [7:0]               r_out_char;

    logic                     w_is_dig, w_is_sp, w_is_eq, w_is_mod, w_is_op, w_is_div, w_illegal;
    logic                     w_flush, w_full, w_ovf, w_under, w_div0, w_bad_eq;
    logic [CW:0]              w_cnt_f;
    logic [AW-1:0]            w_i1, w_i2, w_iw, w_ir;
    logic signed [WIDTH-1:0]  w_a, w_b, w_bs, w_res;
    logic [WIDTH-1:0]         w_abs, w_mag_q;
    logic [3:0]               w_digit;

    assign w_is_dig = (r_char >= 8'h30) && (r_char <= 8'h39);
    assign w_is_sp  = (r_char == 8'h20);
    assign w_is_eq  = (r_char == 8'h3D);
`ifdef RPN_MOD_EN
    assign w_is_mod = (r_char == 8'h25);
`else
    assign w_is_mod = 1'b0;
`endif
    assign w_is_div  = (r_char == 8'h2F) || w_is_mod;
    assign w_is_op   = (r_char == 8'h2B) || (r_char == 8'h2D) || (r_char == 8'h2A) || w_is_div;
    assign w_illegal = !(w_is_dig || w_is_sp || w_is_eq || w_is_op);

    // Operators and '=' first flush a pending number, so operands are taken
    // from the stack as it would look after that push.
    assign w_flush = r_pend && (w_is_sp || w_is_op || w_is_eq);
    assign w_full  = (r_cnt == CW'(DEPTH));
    assign w_ovf   = w_flush && w_full;
    assign w_cnt_f = {1'b0, r_cnt} + {{CW{1'b0}}, w_flush};
    assign w_i1    = AW'(r_cnt - CW'(1));
    assign w_i2    = AW'(r_cnt - CW'(2));
    assign w_iw    = AW'(r_cnt);
    assign w_ir    = AW'(w_cnt_f - (CW+1)'(2));
    assign w_b     = w_flush ? r_acc : r_stack[w_i1];
    assign w_a     = w_flush ? r_stack[w_i1] : r_stack[w_i2];
    assign w_bs    = (w_b == '0) ? WIDTH'(1) : w_b;
    assign w_under = (w_cnt_f < (CW+1)'(2));
    assign w_div0  = w_is_div && (w_b == '0);
    assign w_bad_eq = r_err || w_ovf || (w_cnt_f != (CW+1)'(1));
    assign w_abs   = w_b[WIDTH-1] ? WIDTH'(-w_b) : w_b;
    assign w_mag_q = r_mag / WIDTH'(10);
    assign w_digit = 4'(r_mag % WIDTH'(10));

    always_comb begin
        w_res = '0;
        case (r_char)
            8'h2B:   w_res = w_a + w_b;
            8'h2D:   w_res = w_a - w_b;
            8'h2A:   w_res = w_a * w_b;
            8'h2F:   w_res = w_a / w_bs;
            default: w_res = w_is_mod ? (w_a % w_bs) : '0;
        endcase
    end

    assign IN_ACK   = (r_state == S_IDLE);
    assign OUT_STB  = r_out_stb;
    assign OUT_CHAR = r_out_char;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (IN_STB) w_next = S_EXEC;
            S_EXEC: begin
                if (w_is_eq) w_next = w_bad_eq ? S_SEND : S_CONV;
                else         w_next = S_IDLE;
            end
            S_CONV: if (w_mag_q == '0) w_next = S_SEND;
            S_SEND: if (OUT_ACK && r_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_char     <= '0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_pend     <= 1'b0;
            r_err      <= 1'b0;
            r_mag      <= '0;
            r_neg      <= 1'b0;
            r_ndig     <= '0;
            r_ptr      <= '0;
            r_last     <= 1'b0;
            r_out_stb  <= 1'b0;
            r_out_char <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) r_stack[i] <= '0;
            for (int unsigned i = 0; i < 10; i++)    r_dig[i]   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (IN_STB) r_char <= IN_CHAR;
                S_EXEC: begin
                    if (!r_err) begin
                        if (w_is_dig) begin
                            r_acc  <= r_acc * WIDTH'(10) + WIDTH'(r_char[3:0]);
                            r_pend <= 1'b1;
                        end else if (w_illegal) begin
                            r_err <= 1'b1;
                        end else begin
                            if (w_flush) begin
                                r_pend <= 1'b0;
                                r_acc  <= '0;
                                if (w_full) begin
                                    r_err <= 1'b1;
                                end else begin
                                    r_stack[w_iw] <= r_acc;
                                    r_cnt         <= r_cnt + CW'(1);
                                end
                            end
                            if (w_is_op && !w_ovf) begin
                                if (w_under || w_div0) begin
                                    r_err <= 1'b1;
                                end else begin
                                    r_stack[w_ir] <= w_res;
                                    r_cnt         <= CW'(w_cnt_f - (CW+1)'(1));
                                end
                            end
                        end
                    end
                    if (w_is_eq) begin
                        if (w_bad_eq) begin
                            r_out_char <= 8'h45;
                            r_out_stb  <= 1'b1;
                            r_ptr      <= '0;
                            r_last     <= 1'b0;
                        end else begin
                            r_mag  <= w_abs;
                            r_neg  <= w_b[WIDTH-1];
                            r_ndig <= '0;
                        end
                    end
                end
                S_CONV: begin
                    r_dig[r_ndig] <= w_digit;
                    r_ndig        <= r_ndig + 4'd1;
                    r_mag         <= w_mag_q;
                    // The digit produced on the final cycle is the most significant one,
                    // so it can be presented directly without a round-trip through r_dig.
                    if (w_mag_q == '0) begin
                        r_out_stb <= 1'b1;
                        r_last    <= 1'b0;
                        if (r_neg) begin
                            r_out_char <= 8'h2D;
                            r_ptr      <= r_ndig + 4'd1;
                        end else begin
                            r_out_char <= {4'h3, w_digit};
                            r_ptr      <= r_ndig;
                        end
                    end
                end
                S_SEND: begin
                    if (OUT_ACK) begin
                        if (r_last) begin
                            r_out_stb  <= 1'b0;
                            r_out_char <= '0;
                            r_last     <= 1'b0;
                            r_cnt      <= '0;
                            r_acc      <= '0;
                            r_pend     <= 1'b0;
                            r_err      <= 1'b0;
                        end else if (r_ptr != '0) begin
                            r_out_char <= {4'h3, r_dig[r_ptr - 4'd1]};
                            r_ptr      <= r_ptr - 4'd1;
                        end else begin
                            r_out_char <= 8'h0A;
                            r_last     <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_eval.sv
// Directed testbench for rpn_eval (WIDTH=32, DEPTH=4) with hand-computed expected output lines.
module tb_rpn_eval;

    logic       CLK;
    logic       RST;
    logic       IN_STB;
    logic [7:0] IN_CHAR;
    logic       IN_ACK;
    logic       OUT_STB;
    logic [7:0] OUT_CHAR;
    logic       OUT_ACK;

    int errors = 0;
    int checks = 0;

    rpn_eval #(.WIDTH(32), .DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .IN_STB(IN_STB), .IN_CHAR(IN_CHAR), .IN_ACK(IN_ACK),
        .OUT_STB(OUT_STB), .OUT_CHAR(OUT_CHAR), .OUT_ACK(OUT_ACK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic send_char(input logic [7:0] c);
        int n;
        n = 0;
        @(negedge CLK);
        while (!IN_ACK && n < 500) begin
            @(negedge CLK);
            n++;
        end
        if (!IN_ACK) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: char=%h IN_ACK=%b required 1", c, IN_ACK);
        end
        IN_STB  = 1'b1;
        IN_CHAR = c;
        @(negedge CLK);
        IN_STB  = 1'b0;
    endtask

    task automatic recv_line(output string got, output bit nl);
        int n;
        got = "";
        nl  = 1'b0;
        for (int k = 0; k < 16 && !nl; k++) begin
            n = 0;
            while (!OUT_STB && n < 200) begin
                @(negedge CLK);
                n++;
            end
            if (!OUT_STB) break;
            if (OUT_CHAR == 8'h0A) nl = 1'b1;
            else got = $sformatf("%s%c", got, OUT_CHAR);
            OUT_ACK = 1'b1;
            @(negedge CLK);
            OUT_ACK = 1'b0;
        end
    endtask

    task automatic transact(input string expr, output string got, output bit nl);
        for (int i = 0; i < expr.len(); i++) send_char(expr[i]);
        recv_line(got, nl);
    endtask

    task automatic test_reset();
        RST = 1'b0; IN_STB = 1'b0; IN_CHAR = '0; OUT_ACK = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (IN_ACK !== 1'b1)      begin errors++; $display("FAIL reset_in_ack: got %b required 1", IN_ACK); end
        checks++; if (OUT_STB !== 1'b0)     begin errors++; $display("FAIL reset_out_stb: got %b required 0", OUT_STB); end
        checks++; if (OUT_CHAR !== 8'h00)   begin errors++; $display("FAIL reset_out_char: got %h required 00", OUT_CHAR); end
        RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_add();
        string got; bit nl;
        transact("12 3+=", got, nl);
        checks++; if (!nl || got != "15") begin errors++; $display("FAIL add: got \"%s\" nl=%0b required \"15\" nl=1", got, nl); end
        checks++; if (IN_ACK !== 1'b1)    begin errors++; $display("FAIL add_in_ack_after: got %b required 1", IN_ACK); end
    endtask

    task automatic test_sub_neg();
        string got; bit nl;
        transact("2 7-=", got, nl);
        checks++; if (!nl || got != "-5") begin errors++; $display("FAIL sub_neg: got \"%s\" nl=%0b required \"-5\" nl=1", got, nl); end
    endtask

    task automatic test_wrap();
        string got; bit nl;
        transact("2147483647 1+=", got, nl);
        checks++; if (!nl || got != "-2147483648") begin errors++; $display("FAIL wrap_min: got \"%s\" nl=%0b required \"-2147483648\" nl=1", got, nl); end
    endtask

    task automatic test_arith();
        string got; bit nl;
        transact("6 7*=", got, nl);
        checks++; if (!nl || got != "42") begin errors++; $display("FAIL mul: got \"%s\" nl=%0b required \"42\" nl=1", got, nl); end
        transact("0 7-2/=", got, nl);
        checks++; if (!nl || got != "-3") begin errors++; $display("FAIL div_trunc: got \"%s\" nl=%0b required \"-3\" nl=1", got, nl); end
        transact("0=", got, nl);
        checks++; if (!nl || got != "0") begin errors++; $display("FAIL zero: got \"%s\" nl=%0b required \"0\" nl=1", got, nl); end
        transact("3 4+5*=", got, nl);
        checks++; if (!nl || got != "35") begin errors++; $display("FAIL op_flush: got \"%s\" nl=%0b required \"35\" nl=1", got, nl); end
    endtask

    task automatic test_error_recovery();
        string got; bit nl;
        transact("8 0/=", got, nl);
        checks++; if (!nl || got != "E") begin errors++; $display("FAIL div0: got \"%s\" nl=%0b required \"E\" nl=1", got, nl); end
        transact("4 4*=", got, nl);
        checks++; if (!nl || got != "16") begin errors++; $display("FAIL recover: got \"%s\" nl=%0b required \"16\" nl=1", got, nl); end
    endtask

    task automatic test_underflow();
        string got; bit nl;
        transact("+=", got, nl);
        checks++; if (!nl || got != "E") begin errors++; $display("FAIL underflow: got \"%s\" nl=%0b required \"E\" nl=1", got, nl); end
        transact("1 2=", got, nl);
        checks++; if (!nl || got != "E") begin errors++; $display("FAIL leftover: got \"%s\" nl=%0b required \"E\" nl=1", got, nl); end
        transact("=", got, nl);
        checks++; if (!nl || got != "E") begin errors++; $display("FAIL empty: got \"%s\" nl=%0b required \"E\" nl=1", got, nl); end
    endtask

    task automatic test_overflow();
        string got; bit nl;
        transact("1 2 3 4 5 ++++=", got, nl);
        checks++; if (!nl || got != "E") begin errors++; $display("FAIL overflow: got \"%s\" nl=%0b required \"E\" nl=1", got, nl); end
        transact("1 2 3 4+++=", got, nl);
        checks++; if (!nl || got != "10") begin errors++; $display("FAIL full_ok: got \"%s\" nl=%0b required \"10\" nl=1", got, nl); end
    endtask

    task automatic test_illegal();
        string got; bit nl;
        transact("(1 2+=", got, nl);
        checks++; if (!nl || got != "E") begin errors++; $display("FAIL illegal: got \"%s\" nl=%0b required \"E\" nl=1", got, nl); end
    endtask

    task automatic test_mod();
        string got; bit nl;
        string exp;
`ifdef RPN_MOD_EN
        exp = "2";
`else
        exp = "E";
`endif
        transact("17 5%=", got, nl);
        checks++; if (!nl || got != exp) begin errors++; $display("FAIL mod: got \"%s\" nl=%0b required \"%s\" nl=1", got, nl, exp); end
    endtask

    task automatic test_backpressure();
        string got; bit nl;
        int n;
        string s;
        s = "12 3+=";
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
        n = 0;
        while (!OUT_STB && n < 200) begin @(negedge CLK); n++; end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (OUT_STB !== 1'b1 || OUT_CHAR !== 8'h31 || IN_ACK !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: got stb=%b char=%h in_ack=%b required stb=1 char=31 in_ack=0", c, OUT_STB, OUT_CHAR, IN_ACK);
            end
            @(negedge CLK);
        end
        recv_line(got, nl);
        checks++; if (!nl || got != "15") begin errors++; $display("FAIL stall_line: got \"%s\" nl=%0b required \"15\" nl=1", got, nl); end
    endtask

    task automatic test_reset_mid_send();
        string got; bit nl;
        int n;
        string s;
        s = "12 3+=";
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
        n = 0;
        while (!OUT_STB && n < 200) begin @(negedge CLK); n++; end
        RST = 1'b0;
        #1;
        checks++; if (OUT_STB !== 1'b0 || IN_ACK !== 1'b1 || OUT_CHAR !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_send: got stb=%b in_ack=%b char=%h required stb=0 in_ack=1 char=00", OUT_STB, IN_ACK, OUT_CHAR);
        end
        @(negedge CLK);
        RST = 1'b1;
        transact("5=", got, nl);
        checks++; if (!nl || got != "5") begin errors++; $display("FAIL after_rst: got \"%s\" nl=%0b required \"5\" nl=1", got, nl); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_neg();
        test_wrap();
        test_arith();
        test_error_recovery();
        test_underflow();
        test_overflow();
        test_illegal();
        test_mod();
        test_backpressure();
        test_reset_mid_send();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
